// File: rtl/simd_dispatch_arbiter.sv
// simd_dispatch_arbiter
//   Accepts one kernel descriptor at a time from the warp scheduler.
//   For each descriptor it allocates the lowest free warp ID from a
//   NUM_WARP_IDS-entry pool and picks an idle SIMD core. It then dispatches
//   the descriptor to that core and tracks per-core completion. Retired warp
//   IDs are reported on finished_warp_id, one per cycle.
//
//   Optional feature macro: DISPATCH_RR_ARB_EN
//     defined   -> round-robin core selection starting after the last grant
//     undefined -> fixed priority, lowest-indexed free core wins
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   kin_valid/ready   descriptor handshake from the scheduler
//   kin_pc/threads    descriptor payload (threads==0 is consumed and dropped)
//   disp_valid        one-hot dispatch request, held until disp_ack[sel]
//   disp_pc/threads   dispatched payload (0 while disp_valid is 0)
//   disp_warp_id      allocated warp ID (0 while disp_valid is 0)
//   disp_ack          per-core dispatch accept
//   core_done         per-core one-cycle completion pulse
//   finished_warp_id  retired warp ID for one cycle, 4'b1111 otherwise
//   busy_mask         cores currently holding a warp
//   dbg_state_o       FSM state (0 = IDLE, 1 = DISPATCH)
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready/ack are both high. Valid never depends combinationally on ready,
// and the payload stays stable while valid is high and not yet accepted.
module simd_dispatch_arbiter #(
    parameter int NUM_CORES    = 4,
    parameter int THREAD_W     = 3,
    parameter int NUM_WARP_IDS = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kin_valid,
    input  logic [31:0]          kin_pc,
    input  logic [THREAD_W-1:0]  kin_threads,
    output logic                 kin_ready,
    output logic [NUM_CORES-1:0] disp_valid,
    output logic [31:0]          disp_pc,
    output logic [THREAD_W-1:0]  disp_threads,
    output logic [3:0]           disp_warp_id,
    input  logic [NUM_CORES-1:0] disp_ack,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [3:0]           finished_warp_id,
    output logic [NUM_CORES-1:0] busy_mask,
    output logic                 dbg_state_o
);

    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_DISPATCH = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [THREAD_W-1:0]     thr_q, thr_d;
    logic [3:0]              wid_q, wid_d;
    logic [CW-1:0]           sel_q, sel_d;
    logic [NUM_CORES-1:0]    busy_q, busy_d;
    logic [NUM_CORES-1:0]    pend_q, pend_d;
    logic [NUM_WARP_IDS-1:0] pool_q, pool_d;
    logic [3:0]              slot_q [NUM_CORES];
    logic [3:0]              slot_d [NUM_CORES];
    logic [3:0]              fin_q, fin_d;
`ifdef DISPATCH_RR_ARB_EN
    logic [CW-1:0]           rr_q, rr_d;
`endif

    logic [NUM_CORES-1:0]    core_free;
    logic                    wid_found;
    logic [3:0]              wid_free;
    logic [CW-1:0]           sel_idx;
    logic [NUM_CORES-1:0]    cand;
    logic                    ret_found;
    logic [CW-1:0]           ret_idx;
    logic                    accept;

    // A core with a pending done is still owned until it retires.
    assign core_free = ~busy_q & ~pend_q;

    always_comb begin
        wid_found = 1'b0;
        wid_free  = 4'd0;
        for (int i = NUM_WARP_IDS - 1; i >= 0; i--) begin
            if (!pool_q[i]) begin
                wid_found = 1'b1;
                wid_free  = 4'(i);
            end
        end
    end

    always_comb begin
        sel_idx = '0;
`ifdef DISPATCH_RR_ARB_EN
        // Descending k so the smallest offset from rr_q+1 wins.
        for (int k = NUM_CORES; k >= 1; k--) begin
            if (core_free[(int'(rr_q) + k) % NUM_CORES])
                sel_idx = CW'((int'(rr_q) + k) % NUM_CORES);
        end
`else
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (core_free[c]) sel_idx = CW'(c);
        end
`endif
    end

    // Fresh done pulses join the retire search directly, so an otherwise
    // idle retire path reports the ID in the cycle right after the pulse.
    assign cand = pend_q | (core_done & busy_q);

    always_comb begin
        ret_found = 1'b0;
        ret_idx   = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (cand[c]) begin
                ret_found = 1'b1;
                ret_idx   = CW'(c);
            end
        end
    end

    assign kin_ready = (state_q == S_IDLE) && wid_found && (|core_free);
    assign accept    = kin_valid && kin_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        thr_d   = thr_q;
        wid_d   = wid_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        pool_d  = pool_q;
        slot_d  = slot_q;
        pend_d  = cand;
        fin_d   = 4'hF;
`ifdef DISPATCH_RR_ARB_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Zero-thread descriptors are consumed without allocating.
                if (accept && (kin_threads != '0)) begin
                    pc_d            = kin_pc;
                    thr_d           = kin_threads;
                    wid_d           = wid_free;
                    sel_d           = sel_idx;
                    slot_d[sel_idx] = wid_free;
                    pool_d[wid_free] = 1'b1;
`ifdef DISPATCH_RR_ARB_EN
                    rr_d            = sel_idx;
`endif
                    state_d         = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (disp_ack[sel_q]) begin
                    busy_d[sel_q] = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Retirement frees resources from registered state, so the allocator
        // above never sees a resource freed in this same cycle.
        if (ret_found) begin
            fin_d                   = slot_q[ret_idx];
            pend_d[ret_idx]         = 1'b0;
            busy_d[ret_idx]         = 1'b0;
            pool_d[slot_q[ret_idx]] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            thr_q   <= '0;
            wid_q   <= '0;
            sel_q   <= '0;
            busy_q  <= '0;
            pend_q  <= '0;
            pool_q  <= '0;
            fin_q   <= 4'hF;
            for (int c = 0; c < NUM_CORES; c++) slot_q[c] <= 4'hF;
`ifdef DISPATCH_RR_ARB_EN
            rr_q    <= CW'(NUM_CORES - 1);
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            thr_q   <= thr_d;
            wid_q   <= wid_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            pool_q  <= pool_d;
            fin_q   <= fin_d;
            slot_q  <= slot_d;
`ifdef DISPATCH_RR_ARB_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        disp_valid   = '0;
        disp_pc      = '0;
        disp_threads = '0;
        disp_warp_id = '0;
        if (state_q == S_DISPATCH) begin
            disp_valid[sel_q] = 1'b1;
            disp_pc           = pc_q;
            disp_threads      = thr_q;
            disp_warp_id      = wid_q;
        end
    end

    assign finished_warp_id = fin_q;
    assign busy_mask        = busy_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_simd_dispatch_arbiter.sv
module tb_simd_dispatch_arbiter;

    localparam int NC = 4;
    localparam int TW = 3;

    logic          clk;
    logic          rst;
    logic          kin_valid;
    logic [31:0]   kin_pc;
    logic [TW-1:0] kin_threads;
    logic          kin_ready;
    logic [NC-1:0] disp_valid;
    logic [31:0]   disp_pc;
    logic [TW-1:0] disp_threads;
    logic [3:0]    disp_warp_id;
    logic [NC-1:0] disp_ack;
    logic [NC-1:0] core_done;
    logic [3:0]    finished_warp_id;
    logic [NC-1:0] busy_mask;
    logic          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    simd_dispatch_arbiter #(.NUM_CORES(NC), .THREAD_W(TW), .NUM_WARP_IDS(15)) dut (
        .clk              (clk),
        .rst              (rst),
        .kin_valid        (kin_valid),
        .kin_pc           (kin_pc),
        .kin_threads      (kin_threads),
        .kin_ready        (kin_ready),
        .disp_valid       (disp_valid),
        .disp_pc          (disp_pc),
        .disp_threads     (disp_threads),
        .disp_warp_id     (disp_warp_id),
        .disp_ack         (disp_ack),
        .core_done        (core_done),
        .finished_warp_id (finished_warp_id),
        .busy_mask        (busy_mask),
        .dbg_state_o      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled at that same point (all outputs are register-driven)
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [TW-1:0] thr);
        kin_valid   = 1'b1;
        kin_pc      = pc;
        kin_threads = thr;
        tick(1);
        kin_valid   = 1'b0;
    endtask

    task automatic ack(input logic [NC-1:0] m);
        disp_ack = m;
        tick(1);
        disp_ack = '0;
    endtask

    task automatic done(input logic [NC-1:0] m);
        core_done = m;
        tick(1);
        core_done = '0;
    endtask

    logic [TW-1:0] thr_tab [4] = '{3'd4, 3'd1, 3'd2, 3'd7};
    logic [NC-1:0] exp_sel;

    initial begin
        rst = 1'b1; kin_valid = 1'b0; kin_pc = '0; kin_threads = '0;
        disp_ack = '0; core_done = '0;
        tick(2);
        check_value("rst_disp_valid", 32'(disp_valid), 32'h0);
        check_value("rst_disp_pc", disp_pc, 32'h0);
        check_value("rst_fin", 32'(finished_warp_id), 32'hF);
        check_value("rst_busy", 32'(busy_mask), 32'h0);
        check_value("rst_kin_ready", 32'(kin_ready), 32'h1);
        rst = 1'b0;
        tick(1);

        // fill all four cores; first one is PC=0x100 threads=4 -> core 0, ID 0
        for (int i = 0; i < 4; i++) begin
            push(32'h100 * (i + 1), thr_tab[i]);
            check_value("fill_disp_valid", 32'(disp_valid), 32'(1 << i));
            check_value("fill_wid", 32'(disp_warp_id), i);
            check_value("fill_pc", disp_pc, 32'h100 * (i + 1));
            check_value("fill_thr", 32'(disp_threads), 32'(thr_tab[i]));
            check_value("fill_ready_low", 32'(kin_ready), 32'h0);
            ack(NC'(1 << i));
            check_value("fill_busy", 32'(busy_mask), 32'((1 << (i + 1)) - 1));
            check_value("fill_valid_drop", 32'(disp_valid), 32'h0);
            check_value("fill_pc_zero", disp_pc, 32'h0);
        end
        check_value("full_ready", 32'(kin_ready), 32'h0);

        // 5th kernel is held upstream while all cores are busy
        kin_valid = 1'b1; kin_pc = 32'h500; kin_threads = 3'd3;
        tick(2);
        check_value("held_disp_valid", 32'(disp_valid), 32'h0);
        check_value("held_ready", 32'(kin_ready), 32'h0);
        done(4'b0010);
        check_value("ret1_fin", 32'(finished_warp_id), 32'h1);
        check_value("ret1_ready", 32'(kin_ready), 32'h1);
        check_value("ret1_busy", 32'(busy_mask), 32'hD);
        tick(1);
        kin_valid = 1'b0;
        check_value("ret1_fin_clear", 32'(finished_warp_id), 32'hF);
        check_value("reuse_disp_valid", 32'(disp_valid), 32'h2);
        check_value("reuse_wid", 32'(disp_warp_id), 32'h1);
        check_value("reuse_pc", disp_pc, 32'h500);
        ack(4'b0010);
        check_value("reuse_busy", 32'(busy_mask), 32'hF);

        // two completions in one cycle retire in core-index order
        done(4'b1010);
        check_value("dual_fin_a", 32'(finished_warp_id), 32'h1);
        tick(1);
        check_value("dual_fin_b", 32'(finished_warp_id), 32'h3);
        tick(1);
        check_value("dual_fin_idle", 32'(finished_warp_id), 32'hF);
        check_value("dual_busy", 32'(busy_mask), 32'h5);

        // zero-thread descriptor: consumed, nothing dispatched, pool unchanged
        push(32'h600, 3'd0);
        check_value("zero_disp_valid", 32'(disp_valid), 32'h0);
        check_value("zero_ready", 32'(kin_ready), 32'h1);

        // IDs 0,2 in use -> next gets ID 1
`ifdef DISPATCH_RR_ARB_EN
        exp_sel = 4'b1000;  // last grant was core 1, search starts at 2
`else
        exp_sel = 4'b0010;  // lowest free core
`endif
        push(32'h700, 3'd5);
        check_value("stall_wid", 32'(disp_warp_id), 32'h1);
        check_value("stall_disp_valid", 32'(disp_valid), 32'(exp_sel));
        disp_ack = 4'b0100;  // non-selected core: must be ignored
        for (int i = 0; i < 5; i++) begin
            tick(1);
            disp_ack = '0;
            check_value("stall_valid_hold", 32'(disp_valid), 32'(exp_sel));
            check_value("stall_pc_hold", disp_pc, 32'h700);
            check_value("stall_wid_hold", 32'(disp_warp_id), 32'h1);
        end
        #2 rst = 1'b1;
        #1;
        check_value("async_rst_valid", 32'(disp_valid), 32'h0);
        check_value("async_rst_busy", 32'(busy_mask), 32'h0);
        check_value("async_rst_fin", 32'(finished_warp_id), 32'hF);
        tick(1);
        rst = 1'b0;
        tick(1);

        // done on an idle core is ignored
        done(4'b0001);
        check_value("idle_done_fin", 32'(finished_warp_id), 32'hF);

        // refill, retire cores 2 and 3 -> next kernel lands on core 2
        for (int i = 0; i < 4; i++) begin
            push(32'h1000 + i, 3'd1);
            ack(NC'(1 << i));
        end
        check_value("refill_busy", 32'(busy_mask), 32'hF);
        done(4'b0100);
        check_value("ret2_fin", 32'(finished_warp_id), 32'h2);
        done(4'b1000);
        check_value("ret3_fin", 32'(finished_warp_id), 32'h3);
        push(32'h2000, 3'd6);
        check_value("lowfree_disp_valid", 32'(disp_valid), 32'h4);
        check_value("lowfree_wid", 32'(disp_warp_id), 32'h2);

        // done in the same cycle as ack on that core is ignored
        disp_ack = 4'b0100; core_done = 4'b0100;
        tick(1);
        disp_ack = '0; core_done = '0;
        check_value("ackdone_busy", 32'(busy_mask), 32'h7);
        check_value("ackdone_fin", 32'(finished_warp_id), 32'hF);
        tick(1);
        check_value("ackdone_fin_later", 32'(finished_warp_id), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
